// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller user port.
// One transaction at a time: grant, hold until done, one idle cycle.
module sdram_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int ADDRESS_WIDTH  = 22,
  parameter int DATA_WIDTH     = 16,
  parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [2*NUM_REQUESTERS-1:0]         req_command,
  input  logic [ADDRESS_WIDTH*NUM_REQUESTERS-1:0] req_address,
  input  logic [DATA_WIDTH*NUM_REQUESTERS-1:0]    req_write_data,
  output logic [NUM_REQUESTERS-1:0]           req_ack,
  output logic [DATA_WIDTH-1:0]               req_read_data,
  output logic                                grant_valid,
  output logic [ID_WIDTH-1:0]                 grant_id,
  output logic [1:0]                          ctrl_command,
  output logic [ADDRESS_WIDTH-1:0]            ctrl_address,
  output logic [DATA_WIDTH-1:0]               ctrl_write_data,
  input  logic [DATA_WIDTH-1:0]               ctrl_read_data,
  input  logic                                ctrl_read_valid,
  input  logic                                ctrl_write_done
);

  localparam int N = NUM_REQUESTERS;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] ptr;
  logic [ID_WIDTH-1:0] win;
  logic [ID_WIDTH-1:0] win_next;
  logic                found;
  logic                done;
  logic [N-1:0]        pend;
  logic [N-1:0]        ack_mask;
  logic [1:0]          win_cmd;

  always_comb begin
    pend = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = (req_command[2*i +: 2] == 2'd1) ||
                (req_command[2*i +: 2] == 2'd2);
    end
  end

  // first pending client at or above the pointer, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      logic [ID_WIDTH-1:0] jj;
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = ID_WIDTH'(j);
      if (!found && pend[jj]) begin
        found = 1'b1;
        win   = jj;
      end
    end
  end

  assign win_next = (win == ID_WIDTH'(N - 1)) ? '0 : win + 1'b1;
  assign win_cmd  = req_command[2*win +: 2];
  assign ack_mask = {{(N-1){1'b0}}, 1'b1} << grant_id;

  assign done = ((ctrl_command == 2'd1) && ctrl_write_done) ||
                ((ctrl_command == 2'd2) && ctrl_read_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      ptr             <= '0;
      req_ack         <= '0;
      req_read_data   <= '0;
      grant_valid     <= 1'b0;
      grant_id        <= '0;
      ctrl_command    <= 2'd0;
      ctrl_address    <= '0;
      ctrl_write_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            ctrl_command    <= win_cmd;
            ctrl_address    <= req_address[ADDRESS_WIDTH*win +: ADDRESS_WIDTH];
            ctrl_write_data <= req_write_data[DATA_WIDTH*win +: DATA_WIDTH];
            grant_id        <= win;
            grant_valid     <= 1'b1;
            ptr             <= win_next;
            state           <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            ctrl_command <= 2'd0;
            req_ack      <= ack_mask;
            if (ctrl_command == 2'd2) req_read_data <= ctrl_read_data;
            state        <= RELEASE;
          end
        end
        RELEASE: begin
          req_ack     <= '0;
          grant_valid <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small controller model
// and an ack scoreboard.
module tb_sdram_arbiter;

  logic        clk;
  logic        reset_n;
  logic [7:0]  req_command;
  logic [87:0] req_address;
  logic [63:0] req_write_data;
  logic [3:0]  req_ack;
  logic [15:0] req_read_data;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [1:0]  ctrl_command;
  logic [21:0] ctrl_address;
  logic [15:0] ctrl_write_data;
  logic [15:0] ctrl_read_data;
  logic        ctrl_read_valid;
  logic        ctrl_write_done;

  sdram_arbiter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_command     (req_command),
    .req_address     (req_address),
    .req_write_data  (req_write_data),
    .req_ack         (req_ack),
    .req_read_data   (req_read_data),
    .grant_valid     (grant_valid),
    .grant_id        (grant_id),
    .ctrl_command    (ctrl_command),
    .ctrl_address    (ctrl_address),
    .ctrl_write_data (ctrl_write_data),
    .ctrl_read_data  (ctrl_read_data),
    .ctrl_read_valid (ctrl_read_valid),
    .ctrl_write_done (ctrl_write_done)
  );

  typedef struct {
    int          id;
    bit          rd;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  bit          auto_en = 0;
  bit          force_rv = 0;
  bit          force_wd = 0;
  logic [15:0] rd_val = 16'h0;
  logic [3:0]  prev_ack = 4'h0;
  logic [3:0]  exp_mask;
  int          cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic set_req(input int i, input logic [1:0] c,
                         input logic [21:0] a, input logic [15:0] d);
    req_command[2*i +: 2]     = c;
    req_address[22*i +: 22]   = a;
    req_write_data[16*i +: 16] = d;
  endtask

  task automatic wait_q(input int n, input string tag);
    int k;
    k = 0;
    while (sb.size() > n && k < 100) begin
      tick();
      k++;
    end
    chk(tag, 32'(sb.size() <= n), 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #12;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  // controller model: completes a held command after two cycles
  always begin
    @(posedge clk);
    #2;
    ctrl_write_done = force_wd;
    ctrl_read_valid = force_rv;
    ctrl_read_data  = rd_val;
    if (auto_en && reset_n && ctrl_command != 2'd0) begin
      cnt++;
      if (cnt == 2) begin
        cnt = 0;
        if (ctrl_command == 2'd1) ctrl_write_done = 1'b1;
        else ctrl_read_valid = 1'b1;
      end
    end else begin
      cnt = 0;
    end
  end

  // ack monitor against the scoreboard
  always begin
    @(posedge clk);
    #1;
    if (req_ack !== 4'h0) begin
      chk("ack_single_cycle", 32'(prev_ack), 32'h0);
      if (sb.size() == 0) begin
        chk("ack_unexpected", 32'(req_ack), 32'h0);
      end else begin
        e = sb.pop_front();
        exp_mask = 4'b0001 << e.id;
        chk("ack_mask", 32'(req_ack), 32'(exp_mask));
        chk("ack_grant_id", 32'(grant_id), 32'(e.id));
        if (e.rd) chk("ack_rdata", 32'(req_read_data), 32'(e.data));
      end
    end
    prev_ack = req_ack;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n         = 1'b0;
    req_command     = '0;
    req_address     = '0;
    req_write_data  = '0;
    ctrl_read_data  = '0;
    ctrl_read_valid = 1'b0;
    ctrl_write_done = 1'b0;
    #12;
    chk("rst_ctrl_command", 32'(ctrl_command), 0);
    chk("rst_ctrl_address", 32'(ctrl_address), 0);
    chk("rst_ctrl_wdata", 32'(ctrl_write_data), 0);
    chk("rst_req_ack", 32'(req_ack), 0);
    chk("rst_req_rdata", 32'(req_read_data), 0);
    chk("rst_grant_valid", 32'(grant_valid), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    @(negedge clk);
    reset_n = 1'b1;
    auto_en = 1'b1;
    tick();

    // single write from client 2
    set_req(2, 2'd1, 22'h000123, 16'hBEEF);
    chk("t1_cmd_before", 32'(ctrl_command), 0);
    sb.push_back('{2, 1'b0, 16'h0});
    tick();
    chk("t1_cmd", 32'(ctrl_command), 1);
    chk("t1_addr", 32'(ctrl_address), 32'h000123);
    chk("t1_wdata", 32'(ctrl_write_data), 32'hBEEF);
    chk("t1_gid", 32'(grant_id), 2);
    chk("t1_gvalid", 32'(grant_valid), 1);
    wait_q(0, "t1_wait");
    chk("t1_cmd_release", 32'(ctrl_command), 0);
    set_req(2, 2'd0, 22'h0, 16'h0);
    tick();
    chk("t1_ack_gone", 32'(req_ack), 0);
    chk("t1_cmd_idle", 32'(ctrl_command), 0);
    chk("t1_gvalid_low", 32'(grant_valid), 0);

    // read from client 1 at top address
    rd_val = 16'h5A5A;
    set_req(1, 2'd2, 22'h3FFFFF, 16'h0);
    sb.push_back('{1, 1'b1, 16'h5A5A});
    tick();
    chk("t2_addr", 32'(ctrl_address), 32'h3FFFFF);
    chk("t2_cmd", 32'(ctrl_command), 2);
    wait_q(0, "t2_wait");
    set_req(1, 2'd0, 22'h0, 16'h0);
    tick();
    tick();

    // all four requesting continuously from reset
    do_reset();
    rd_val = 16'h1357;
    set_req(0, 2'd1, 22'h000010, 16'h1000);
    set_req(1, 2'd2, 22'h000011, 16'h1001);
    set_req(2, 2'd1, 22'h000012, 16'h1002);
    set_req(3, 2'd2, 22'h000013, 16'h1003);
    sb.push_back('{0, 1'b0, 16'h0});
    sb.push_back('{1, 1'b1, 16'h1357});
    sb.push_back('{2, 1'b0, 16'h0});
    sb.push_back('{3, 1'b1, 16'h1357});
    sb.push_back('{0, 1'b0, 16'h0});
    sb.push_back('{1, 1'b1, 16'h1357});
    wait_q(0, "t3_wait");
    req_command = '0;
    tick();
    tick();
    chk("t3_idle", 32'(grant_valid), 0);

    // pointer now 2: client 3 before client 0
    rd_val = 16'h2468;
    set_req(0, 2'd1, 22'h000020, 16'hAAAA);
    set_req(3, 2'd2, 22'h000030, 16'h0);
    sb.push_back('{3, 1'b1, 16'h2468});
    sb.push_back('{0, 1'b0, 16'h0});
    wait_q(1, "t4_wait_first");
    set_req(3, 2'd0, 22'h0, 16'h0);
    wait_q(0, "t4_wait_second");
    set_req(0, 2'd0, 22'h0, 16'h0);
    tick();
    tick();

    // spurious read_valid during a write is ignored
    auto_en = 1'b0;
    set_req(0, 2'd1, 22'h000040, 16'h7777);
    sb.push_back('{0, 1'b0, 16'h0});
    tick();
    chk("t5_cmd", 32'(ctrl_command), 1);
    force_rv = 1'b1;
    tick();
    force_rv = 1'b0;
    tick();
    chk("t5_no_ack", 32'(req_ack), 0);
    chk("t5_still_busy", 32'(ctrl_command), 1);
    chk("t5_gvalid", 32'(grant_valid), 1);
    tick();
    force_wd = 1'b1;
    tick();
    force_wd = 1'b0;
    wait_q(0, "t5_wait");
    chk("t5_rdata_kept", 32'(req_read_data), 32'h2468);
    set_req(0, 2'd0, 22'h0, 16'h0);
    tick();
    tick();

    // reset while busy, then re-arbitrate from pointer 0
    rd_val = 16'hF00D;
    set_req(2, 2'd2, 22'h2AAAAA, 16'h0);
    set_req(3, 2'd1, 22'h155555, 16'hC0DE);
    tick();
    chk("t6_gid", 32'(grant_id), 2);
    chk("t6_cmd", 32'(ctrl_command), 2);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_cmd", 32'(ctrl_command), 0);
    chk("t6_rst_gvalid", 32'(grant_valid), 0);
    chk("t6_rst_ack", 32'(req_ack), 0);
    @(negedge clk);
    sb.push_back('{2, 1'b1, 16'hF00D});
    sb.push_back('{3, 1'b0, 16'h0});
    auto_en = 1'b1;
    reset_n = 1'b1;
    wait_q(1, "t6_wait_first");
    set_req(2, 2'd0, 22'h0, 16'h0);
    wait_q(0, "t6_wait_second");
    set_req(3, 2'd0, 22'h0, 16'h0);
    tick();
    tick();
    chk("t6_final_idle", 32'(grant_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
